pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised fetch program-counter unit for the pipelined CPU with I-cache stall support. It holds the current fetch address and advances it by a fixed increment. Priority rules cover cache stall, hazard hold (PCWrite) and branch/jump redirect. A redirect that arrives while the cache stalls is captured in a one-entry pending buffer and applied once the stall clears. Sits at the head of the IF stage, driving the instruction memory/I-cache address and the IF/ID pc+INC path.

Parameters:
ADDR_W, 32, width of pc_o, pc_plus_o, redirect_pc_i
RESET_PC, 0, value loaded into pc_o on reset (ADDR_W bits)
INC, 4, sequential increment added per advance
ALIGN_BITS, 2, low bits of redirect_pc_i forced to 0 on load (0 = no alignment)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  run enable; low = fetch halted, pc holds
stall_i  in  1  memory/cache stall; freezes pc unconditionally
pc_write_i  in  1  hazard-unit advance enable; 0 = load-use hold
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_pc_i  in  ADDR_W  redirect target
pc_o  out  ADDR_W  current fetch address (registered)
pc_plus_o  out  ADDR_W  pc_o + INC, combinational, modulo 2^ADDR_W
pc_valid_o  out  1  registered; 1 when unit is in RUN
redirect_pending_o  out  1  registered; 1 when pending buffer holds a target

Behaviour:
- Reset (rst_i=0, async, any time incl. mid-stall): pc_o=RESET_PC, state=IDLE, pc_valid_o=0, pending buffer cleared (redirect_pending_o=0, pend_pc=0). Takes effect immediately, not at the next edge.
- States: IDLE, RUN. pc_valid_o is 1 exactly when state=RUN.
- IDLE -> RUN on the rising edge where start_i=1. In that same edge pc_o is not updated. First RUN cycle presents the held pc_o.
- RUN -> IDLE on an edge with start_i=0. pc_o holds its value, not RESET_PC.
- In IDLE: pc_o holds. redirect_valid_i=1 loads the pending buffer (newest wins). stall_i and pc_write_i are ignored.
- In RUN, per rising edge, first matching rule applies:
  1. stall_i=1: pc_o holds. If redirect_valid_i=1, pending <= aligned redirect_pc_i and the pending flag is set (overwrites any older pending target).
  2. redirect_valid_i=1: pc_o <= aligned redirect_pc_i. Pending flag cleared (discarded).
  3. pending flag=1: pc_o <= pend_pc. Pending flag cleared.
  4. pc_write_i=1: pc_o <= pc_o + INC.
  5. otherwise pc_o holds.
- A redirect overrides pc_write_i=0; flushes beat hazard holds.
- Alignment: target with the low ALIGN_BITS bits cleared, before storing or loading.
- Arithmetic: unsigned, truncated to ADDR_W. pc_o + INC wraps from 2^ADDR_W-INC to 0 with no flag.
- Latency: redirect seen at edge N appears on pc_o after edge N (1 cycle), or after the first non-stall edge if stalled.
- redirect_pending_o reflects the registered flag and updates on the same edge as the buffer.
- No X propagation: all registers have a reset value. Inputs are sampled only on the rising edge.

Test Plan:
- Reset/start: rst_i=0 then 1, start_i=0 for 3 cycles -> pc_o=0, pc_valid_o=0. Raise start_i, pc_write_i=1 -> pc_valid_o=1 next edge, then pc_o 0,4,8,12.
- Stall freeze: at pc_o=0x10, stall_i=1 for 5 cycles with pc_write_i=1 -> pc_o stays 0x10. Stall drops -> 0x14.
- Hazard vs redirect: pc_write_i=0 at pc_o=0x20 -> holds. Same cycle redirect_valid_i=1, redirect_pc_i=0x103 -> pc_o=0x100 next edge (aligned).
- Redirect during stall: stall_i=1, redirect 0x200 then 0x300 on consecutive cycles -> redirect_pending_o=1, pc_o unchanged. Stall clears -> pc_o=0x300, redirect_pending_o=0 one edge later. Next sequential value is 0x304.
- Redirect-at-release collision: pending=0x300, stall drops on the same edge as redirect 0x400 -> pc_o=0x400, pending cleared, 0x300 never fetched.
- Wrap and async reset: ADDR_W=8, INC=4, pc_o=0xFC, advance -> 0x00, pc_plus_o=0x04. Assert rst_i mid-cycle while stalled with a pending target -> pc_o=RESET_PC, pc_valid_o=0, redirect_pending_o=0 before the next clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with stall-deferred redirect buffer
module pc_unit #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              pc_write_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              pc_valid_o,
    output logic              redirect_pending_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

    state_t            state;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] target_pc;

    assign target_pc = redirect_pc_i & ALIGN_MASK;
    assign pc_plus_o = pc_o + ADDR_W'(INC);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= ST_IDLE;
            pc_o               <= RESET_PC;
            pc_valid_o         <= 1'b0;
            pend_pc            <= '0;
            redirect_pending_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // While halted a redirect is parked, never applied directly
                    if (redirect_valid_i) begin
                        pend_pc            <= target_pc;
                        redirect_pending_o <= 1'b1;
                    end
                    if (start_i) begin
                        state      <= ST_RUN;
                        pc_valid_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        state      <= ST_IDLE;
                        pc_valid_o <= 1'b0;
                        if (redirect_valid_i) begin
                            pend_pc            <= target_pc;
                            redirect_pending_o <= 1'b1;
                        end
                    end else if (stall_i) begin
                        if (redirect_valid_i) begin
                            pend_pc            <= target_pc;
                            redirect_pending_o <= 1'b1;
                        end
                    end else if (redirect_valid_i) begin
                        // A fresh redirect supersedes whatever was parked
                        pc_o               <= target_pc;
                        redirect_pending_o <= 1'b0;
                    end else if (redirect_pending_o) begin
                        pc_o               <= pend_pc;
                        redirect_pending_o <= 1'b0;
                    end else if (pc_write_i) begin
                        pc_o <= pc_plus_o;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    pc_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
